// File: rtl/ram_load_unit_pkg.sv
// Shared types and helpers for the RAM load path: access-size encodings,
// load FSM states and the alignment rule.
package ram_load_unit_pkg;

  localparam int RAM_QUAD_SIZE = 64;

  typedef enum logic [1:0] {
    RAM_BYTE = 2'd0,
    RAM_WORD = 2'd1,
    RAM_LONG = 2'd2,
    RAM_QUAD = 2'd3
  } ram_size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } load_state_t;

  // An access is aligned when its byte offset inside the quad is a multiple of its size.
  function automatic logic is_aligned(input ram_size_t size, input logic [2:0] offset);
    logic ok;
    case (size)
      RAM_BYTE: ok = 1'b1;
      RAM_WORD: ok = (offset[0] == 1'b0);
      RAM_LONG: ok = (offset[1:0] == 2'b00);
      RAM_QUAD: ok = (offset == 3'b000);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ram_load_unit_if.sv
// Request, RAM read port and response signals of the load unit.
// slave = the load unit itself, master = the surrounding CPU/RAM environment.
interface ram_load_unit_if
  import ram_load_unit_pkg::*;
#(
  parameter int ADDR_W = 16
);

  logic                     req_valid;
  logic                     req_ready;
  logic [ADDR_W-1:0]        req_addr;
  ram_size_t                req_size;
  logic                     req_signed;

  logic                     ram_rd_en;
  logic [ADDR_W-4:0]        ram_addr;
  logic [RAM_QUAD_SIZE-1:0] ram_rd_data;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [RAM_QUAD_SIZE-1:0] rsp_data;
  logic                     rsp_err;

  modport slave (
    input  req_valid, req_addr, req_size, req_signed,
    output req_ready,
    output ram_rd_en, ram_addr,
    input  ram_rd_data,
    output rsp_valid, rsp_data, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_addr, req_size, req_signed,
    input  req_ready,
    input  ram_rd_en, ram_addr,
    output ram_rd_data,
    input  rsp_valid, rsp_data, rsp_err,
    output rsp_ready
  );

endinterface

// File: rtl/ram_load_unit_quad_rshift.sv
// Combinational right shift of a quad by offset*8 bits, followed by masking to
// the access size and sign or zero extension back to 64 bits.
module ram_load_unit_quad_rshift
  import ram_load_unit_pkg::*;
(
  input  logic [RAM_QUAD_SIZE-1:0] data_i,
  input  logic [2:0]               offset_i,
  input  ram_size_t                size_i,
  input  logic                     signed_i,
  output logic [RAM_QUAD_SIZE-1:0] data_o
);

  logic [RAM_QUAD_SIZE-1:0] shifted_s;
  logic                     fill_s;

  // Offset 0 is bits [7:0]; the addressed field lands at the bottom after the shift.
  always_comb begin
    shifted_s = data_i >> {offset_i, 3'b000};
    fill_s    = 1'b0;
    data_o    = shifted_s;
    case (size_i)
      RAM_BYTE: begin
        fill_s = signed_i & shifted_s[7];
        data_o = {{56{fill_s}}, shifted_s[7:0]};
      end
      RAM_WORD: begin
        fill_s = signed_i & shifted_s[15];
        data_o = {{48{fill_s}}, shifted_s[15:0]};
      end
      RAM_LONG: begin
        fill_s = signed_i & shifted_s[31];
        data_o = {{32{fill_s}}, shifted_s[31:0]};
      end
      RAM_QUAD: begin
        fill_s = 1'b0;
        data_o = shifted_s;
      end
      default: begin
        fill_s = 1'b0;
        data_o = shifted_s;
      end
    endcase
  end

endmodule

// File: rtl/ram_load_unit.sv
// Load unit: accepts one request, issues a single aligned quad read and returns the
// extracted, extended field. Misaligned requests get an error response without a RAM access.
module ram_load_unit
  import ram_load_unit_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int RD_LATENCY = 1
) (
  input logic            clk,
  input logic            rst_n,
  ram_load_unit_if.slave bus
);

  localparam int         QA_W     = ADDR_W - 3;
  localparam logic [1:0] LAT_INIT = 2'(RD_LATENCY - 1);

  load_state_t              state_q;
  logic [2:0]               offset_q;
  ram_size_t                size_q;
  logic                     signed_q;
  logic [1:0]               cnt_q;
  logic                     req_ready_q;
  logic                     ram_rd_en_q;
  logic [QA_W-1:0]          ram_addr_q;
  logic                     rsp_valid_q;
  logic                     rsp_err_q;
  logic [RAM_QUAD_SIZE-1:0] rsp_data_q;
  logic [RAM_QUAD_SIZE-1:0] rsp_data_d;

  ram_load_unit_quad_rshift u_rshift (
    .data_i   (bus.ram_rd_data),
    .offset_i (offset_q),
    .size_i   (size_q),
    .signed_i (signed_q),
    .data_o   (rsp_data_d)
  );

  // Load FSM; every output is a register updated on the transition into its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      offset_q    <= 3'd0;
      size_q      <= RAM_BYTE;
      signed_q    <= 1'b0;
      cnt_q       <= 2'd0;
      req_ready_q <= 1'b1;
      ram_rd_en_q <= 1'b0;
      ram_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            offset_q    <= bus.req_addr[2:0];
            size_q      <= bus.req_size;
            signed_q    <= bus.req_signed;
            req_ready_q <= 1'b0;
            if (is_aligned(bus.req_size, bus.req_addr[2:0])) begin
              state_q     <= ST_READ;
              ram_rd_en_q <= 1'b1;
              ram_addr_q  <= bus.req_addr[ADDR_W-1:3];
            end else begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '0;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        ST_READ: begin
          ram_rd_en_q <= 1'b0;
          cnt_q       <= LAT_INIT;
          state_q     <= ST_WAIT;
        end
        ST_WAIT: begin
          // Counter reaching zero marks the single cycle in which ram_rd_data is valid.
          if (cnt_q == 2'd0) begin
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            rsp_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          ram_rd_en_q <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.ram_rd_en = ram_rd_en_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: doc/ram_load_unit.md
Name: ram_load_unit

Overview:
- Read-side counterpart to the store-path quad left shifter.
- Accepts a load request (byte address, size, signedness) and issues one aligned quad read to RAM.
- Right-shifts the returned 64-bit quad by the byte offset, masks it to the access size, and sign- or zero-extends to 64 bits.
- Sits between the CPU load stage / dev loader and the RAM read port.

Parameters:
ADDR_W, 16, byte address width; RAM quad address is ADDR_W-3 bits
RD_LATENCY, 1, cycles from ram_rd_en to valid ram_rd_data (1..4)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  load request valid
req_ready  output  1  unit can accept a request
req_addr  input  ADDR_W  byte address
req_size  input  2  access size: RAM_BYTE, RAM_WORD, RAM_LONG, RAM_QUAD
req_signed  input  1  1 = sign-extend, 0 = zero-extend
ram_rd_en  output  1  RAM read strobe
ram_addr  output  ADDR_W-3  quad address
ram_rd_data  input  RAM_QUAD_SIZE  RAM read data
rsp_valid  output  1  response valid
rsp_ready  input  1  consumer accepts response
rsp_data  output  RAM_QUAD_SIZE  extended load result
rsp_err  output  1  misaligned access

Behaviour:
- Reset (async, rst_n low): state=IDLE, req_ready=1, ram_rd_en=0, ram_addr=0, rsp_valid=0, rsp_data=0, rsp_err=0, latency counter=0. A transaction in flight is dropped; no response is produced after reset.
- Byte order: offset 0 = bits [7:0] of the quad, matching the store-path shift by offset*8.
- Alignment rule, with offset = req_addr[2:0]:
  - byte: any offset.
  - word: offset[0]=0.
  - long: offset[1:0]=0.
  - quad: offset=0.
- FSM states: IDLE, READ, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr, size and signed.
  - Misaligned request -> RESP with rsp_err=1, rsp_data=0. No RAM access.
  - Aligned request -> READ.
- READ (1 cycle): ram_rd_en=1, ram_addr=latched addr[ADDR_W-1:3]; load counter with RD_LATENCY-1; go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, ram_rd_data is valid: register the extracted result into rsp_data with rsp_err=0, then go to RESP.
  - ram_addr holds its value; ram_rd_en=0.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err are stable until rsp_valid && rsp_ready.
  - On handshake -> IDLE, rsp_valid drops the next cycle.
  - req_ready=0 in every state except IDLE; no pipelining, one transaction outstanding.
- Latency with RD_LATENCY=1 and accept at edge N:
  - ram_rd_en in cycle N+1.
  - rsp_valid in cycle N+3.
  - Misaligned: rsp_valid in cycle N+1.
- Extraction: shifted = ram_rd_data >> (offset*8).
  - Width field: 8, 16, 32 or 64 bits per size.
  - Upper bits = replicated field MSB if signed, else 0.
  - Quad ignores req_signed.
- Simultaneous rsp_ready and a new req_valid in RESP: the request is not accepted that cycle; it is accepted in the following IDLE cycle.
- ram_rd_data is ignored outside the capture cycle.

Decomposition:
- pkg_ram additions: RAM_QUAD_SIZE (existing), size encodings RAM_BYTE=0, RAM_WORD=1, RAM_LONG=2, RAM_QUAD=3, a typedef ram_size_t (2-bit), and a function is_aligned(size, offset).
- Sub-module quad_rshift: combinational (data_in, offset[2:0], size, signed) -> data_out. Does the right shift and extension; mirrors the store-path shifter and is testable alone.
- ram_load_unit holds the FSM, latency counter and registers.

Test Plan:
- All cases use quad 1 = 0x8877665544332211 and RD_LATENCY=1.
- Byte load addr 0x000F, signed -> rsp_data 0xFFFFFFFFFFFFFF88; unsigned -> 0x0000000000000088; ram_addr=0x0001; rsp_valid 3 cycles after accept.
- Word addr 0x000A unsigned -> 0x4433; long addr 0x000C signed -> 0xFFFFFFFF88776655; quad addr 0x0008 -> 0x8877665544332211.
- Misaligned word addr 0x0009 -> rsp_err=1, rsp_data=0 one cycle after accept; ram_rd_en never asserted.
- Backpressure: rsp_ready low 4 cycles in RESP -> rsp_valid, rsp_data and rsp_err stable, req_ready=0; completes on the first rsp_ready=1.
- Reset mid-op: rst_n low during WAIT -> outputs immediately at reset values; after release no stale rsp_valid, and the next load returns correct data.
- RD_LATENCY=3 rebuild: byte load addr 0x0008 -> 0x11, rsp_valid 5 cycles after accept.
